dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 13 +
 rtl/dmem_arbiter_rr_arb2.sv | 27 ++
 rtl/dmem_arbiter.sv | 108 ++++++++++
 tb/tb_dmem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: default widths and FSM encoding.
package dmem_arbiter_pkg;

    localparam int unsigned AW_DEF = 32;
    localparam int unsigned DW_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker; a tie goes to the requester not granted last.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic       pick_c,
    output logic       valid_c
);

    logic last;

    always_comb begin
        valid_c = |req;
        pick_c  = (req == 2'b11) ? ~last : req[1];
    end

    // Reset to "m1 granted last" so m0 wins the first tie after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (take && valid_c) begin
            last <= pick_c;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the core (m0) and coprocessor/DMA (m1) onto one single-port data memory
// with a fixed three-cycle request/issue/response sequence.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wd,
    output logic [DW-1:0] m0_rd,
    output logic          m0_ack,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wd,
    output logic [DW-1:0] m1_rd,
    output logic          m1_ack,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,

    output logic          hold,
    output logic          owner
);

    state_t state;
    logic   pick_c;
    logic   valid_c;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .req     ({m1_req, m0_req}),
        .take    (state == IDLE),
        .pick_c  (pick_c),
        .valid_c (valid_c)
    );

    // The mem_* registers double as the latched command; they are only non-zero in ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_wd   <= '0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_c) begin
                        owner    <= pick_c;
                        mem_en   <= 1'b1;
                        mem_we   <= pick_c ? m1_we   : m0_we;
                        mem_addr <= pick_c ? m1_addr : m0_addr;
                        mem_wd   <= pick_c ? m1_wd   : m0_wd;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en   <= 1'b0;
                    mem_we   <= 1'b0;
                    mem_addr <= '0;
                    mem_wd   <= '0;
                    m0_ack   <= ~owner;
                    m1_ack   <= owner;
                    state    <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory read data arrives during RESP, so the return path is steered combinationally.
    always_comb begin
        m0_rd = '0;
        m1_rd = '0;
        if (state == RESP) begin
            if (owner) begin
                m1_rd = mem_rd;
            end else begin
                m0_rd = mem_rd;
            end
        end
    end

    assign hold = m0_req & ~m0_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: memory model plus expected command/ack queues
// stamped with the cycle on which each must appear.
module tb_dmem_arbiter;

    typedef struct {
        logic        who;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wd = '0;
    logic [31:0] m0_rd;
    logic        m0_ack;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wd = '0;
    logic [31:0] m1_rd;
    logic        m1_ack;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wd;
    logic [31:0] mem_rd;
    logic        hold, owner;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t cmd_q[$];
    exp_t ack_q[$];
    logic [31:0] mem [0:255];

    dmem_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wd    (m0_wd),
        .m0_rd    (m0_rd),
        .m0_ack   (m0_ack),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wd    (m1_wd),
        .m1_rd    (m1_rd),
        .m1_ack   (m1_ack),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd),
        .hold     (hold),
        .owner    (owner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data one cycle after mem_en, zero after a write, junk otherwise.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        mem[8'h10] <= 32'hDEADBEEF;
        mem[8'h04] <= 32'h1111_0010;
        mem[8'h05] <= 32'h2222_0014;
        mem[8'h08] <= 32'h3333_0020;
        mem[8'h0A] <= 32'h4444_0028;
        mem[8'h11] <= 32'h5555_0044;
        mem[8'h12] <= 32'h6666_0048;
        mem_rd     <= 32'hBAD0_0000;
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) begin
                    mem[mem_addr[9:2]] <= mem_wd;
                    mem_rd <= 32'h0;
                end else begin
                    mem_rd <= mem[mem_addr[9:2]];
                end
            end else begin
                mem_rd <= 32'hBAD0_0000 | 32'(cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Per-cycle monitor: pops the scoreboard whenever the DUT issues a command or an ack.
    always @(negedge clk) begin : mon
        exp_t e;
        if (mem_en) begin
            if (cmd_q.size() == 0) begin
                check("cmd_unexpected", 64'(1), 64'(0));
            end else begin
                e = cmd_q.pop_front();
                check("cmd_cyc",   64'(cyc),      64'(e.cyc));
                check("cmd_owner", 64'(owner),    64'(e.who));
                check("cmd_we",    64'(mem_we),   64'(e.we));
                check("cmd_addr",  64'(mem_addr), 64'(e.addr));
                check("cmd_wd",    64'(mem_wd),   64'(e.wd));
            end
        end
        if (m0_ack || m1_ack) begin
            if (ack_q.size() == 0) begin
                check("ack_unexpected", 64'(1), 64'(0));
            end else begin
                e = ack_q.pop_front();
                check("ack_cyc", 64'(cyc),    64'(e.cyc));
                check("ack_m0",  64'(m0_ack), 64'(!e.who));
                check("ack_m1",  64'(m1_ack), 64'(e.who));
                check("ack_rd",  64'(e.who ? m1_rd : m0_rd), 64'(e.rd));
                check("ack_other_rd", 64'(e.who ? m0_rd : m1_rd), 64'(0));
            end
        end else begin
            check("rd_gated", {m0_rd, m1_rd}, 64'(0));
        end
        check("we_without_en", 64'(mem_we & ~mem_en), 64'(0));
    end

    task automatic to_cycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic who, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int t);
        exp_t e;
        e.who = who; e.we = we; e.addr = addr; e.wd = wd; e.rd = rd; e.cyc = t + 1;
        cmd_q.push_back(e);
        e.cyc = t + 2;
        ack_q.push_back(e);
    endtask

    task automatic drive(input logic who, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd);
        if (who) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wd = wd;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wd = wd;
        end
    endtask

    // One lone transaction with hold tracked across it.
    task automatic single(input logic who, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd);
        int t;
        t = cyc;
        drive(who, we, addr, wd);
        push(who, we, addr, wd, rd, t);
        @(negedge clk); check("hold_req",   64'(hold), 64'(!who));
        @(negedge clk); check("hold_issue", 64'(hold), 64'(!who));
        @(negedge clk); check("hold_ack",   64'(hold), 64'(0));
        to_cycle(t + 3);
        if (who) m1_req = 1'b0; else m0_req = 1'b0;
    endtask

    // Both request together; m0 must be served first when the pointer favours it.
    task automatic tie_pair(input logic [31:0] a0, input logic [31:0] d0,
                            input logic [31:0] a1, input logic [31:0] d1);
        int t;
        t = cyc;
        drive(1'b0, 1'b0, a0, 32'h0);
        drive(1'b1, 1'b0, a1, 32'h0);
        push(1'b0, 1'b0, a0, 32'h0, d0, t);
        push(1'b1, 1'b0, a1, 32'h0, d1, t + 3);
        to_cycle(t + 3);
        m0_req = 1'b0;
        to_cycle(t + 6);
        m1_req = 1'b0;
    endtask

    initial begin
        int t;

        // Reset state, with m0_req high to see hold follow it.
        m0_req = 1'b1;
        #12;
        check("rst_outputs", {mem_en, mem_we, m0_ack, m1_ack, owner}, 64'(0));
        check("rst_bus", {mem_addr, mem_wd}, 64'(0));
        check("rst_rd", {m0_rd, m1_rd}, 64'(0));
        check("rst_hold", 64'(hold), 64'(1));
        m0_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        to_cycle(cyc + 2);

        // Single read from 0x40.
        single(1'b0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
        to_cycle(cyc + 1);

        // Tie straight after a reset.
        rst = 1'b1;
        to_cycle(cyc + 1);
        rst = 1'b0;
        to_cycle(cyc + 1);
        tie_pair(32'h44, 32'h5555_0044, 32'h48, 32'h6666_0048);
        to_cycle(cyc + 1);

        // m1 write.
        single(1'b1, 1'b1, 32'h80, 32'h1234, 32'h0);
        to_cycle(cyc + 1);

        // Continuous contention for 12 cycles.
        t = cyc;
        drive(1'b0, 1'b0, 32'h10, 32'h0);
        drive(1'b1, 1'b0, 32'h14, 32'h0);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) push(1'b0, 1'b0, 32'h10, 32'h0, 32'h1111_0010, t + 3 * k);
            else            push(1'b1, 1'b0, 32'h14, 32'h0, 32'h2222_0014, t + 3 * k);
        end
        to_cycle(t + 12);
        m0_req = 1'b0;
        m1_req = 1'b0;
        to_cycle(cyc + 1);

        // Inputs change while a command is in flight.
        t = cyc;
        drive(1'b0, 1'b0, 32'h20, 32'h0);
        push(1'b0, 1'b0, 32'h20, 32'h0, 32'h3333_0020, t);
        to_cycle(t + 1);
        m0_addr = 32'h24;
        m0_we   = 1'b1;
        drive(1'b1, 1'b0, 32'h28, 32'h0);
        push(1'b1, 1'b0, 32'h28, 32'h0, 32'h4444_0028, t + 3);
        to_cycle(t + 2);
        m0_addr = 32'h2C;
        to_cycle(t + 3);
        m0_req = 1'b0;
        m0_we  = 1'b0;
        to_cycle(t + 6);
        m1_req = 1'b0;
        to_cycle(cyc + 1);

        // Reset during ISSUE: command seen, then aborted with no ack.
        t = cyc;
        drive(1'b0, 1'b0, 32'h40, 32'h0);
        begin
            exp_t e;
            e.who = 1'b0; e.we = 1'b0; e.addr = 32'h40; e.wd = 32'h0; e.rd = 32'h0; e.cyc = t + 1;
            cmd_q.push_back(e);
        end
        to_cycle(t + 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_outputs", {mem_en, mem_we, m0_ack, m1_ack, owner}, 64'(0));
        check("abort_bus", {mem_addr, mem_wd}, 64'(0));
        check("abort_rd", {m0_rd, m1_rd}, 64'(0));
        check("abort_hold", 64'(hold), 64'(1));
        m0_req = 1'b0;
        to_cycle(t + 3);
        rst = 1'b0;
        to_cycle(cyc + 1);
        tie_pair(32'h40, 32'hDEADBEEF, 32'h48, 32'h6666_0048);
        to_cycle(cyc + 1);

        // Write then read back through the memory.
        single(1'b0, 1'b1, 32'h30, 32'h55AA, 32'h0);
        to_cycle(cyc + 1);
        single(1'b0, 1'b0, 32'h30, 32'h0, 32'h55AA);
        to_cycle(cyc + 4);

        check("cmd_q_drained", 64'(cmd_q.size()), 64'(0));
        check("ack_q_drained", 64'(ack_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
